// File: rtl/lane_deskew_buffer_if.sv
// Port bundle for lane_deskew_buffer: two input lanes, the paired output
// handshake, and per-lane status.
interface lane_deskew_buffer_if #(
  parameter int DATA_WIDTH = 24,
  parameter int PTR_W      = 4
);
  logic                  clear;
  logic                  a_valid;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  b_valid;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  out_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_a;
  logic [DATA_WIDTH-1:0] out_b;
  logic [PTR_W:0]        a_level;
  logic [PTR_W:0]        b_level;
  logic                  a_full;
  logic                  b_full;
  logic                  overflow;

  modport master (
    output clear, a_valid, a_data, b_valid, b_data, out_ready,
    input  out_valid, out_a, out_b, a_level, b_level, a_full, b_full, overflow
  );

  modport slave (
    input  clear, a_valid, a_data, b_valid, b_data, out_ready,
    output out_valid, out_a, out_b, a_level, b_level, a_full, b_full, overflow
  );
endinterface

// File: rtl/lane_deskew_buffer.sv
// Re-pairs two lanes of unequal upstream latency in arrival order and emits
// aligned (a, b) pairs from a registered valid/ready output stage.
module lane_deskew_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 16,
  parameter int PTR_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [PTR_W:0]        level,
  output logic                  nonempty,
  output logic                  full,
  output logic                  drop
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  push;

  assign full     = (level == (PTR_W+1)'(DEPTH));
  assign nonempty = (level != '0);
  // A slot freed by a same-cycle pop lets a push land even when full.
  assign push     = in_valid && !clear && (!full || pop);
  assign drop     = in_valid && !clear && full && !pop;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end
endmodule

module lane_deskew_buffer #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 16,
  parameter int PTR_W      = 4
) (
  input logic                 clk,
  input logic                 rst,
  lane_deskew_buffer_if.slave bus
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]                 lane_valid, lane_nonempty, lane_full, lane_drop;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_data, lane_head;
  logic [NUM_LANES-1:0][PTR_W:0]        lane_level;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_a_q, out_b_q;
  logic                  overflow_q;
  logic                  load_ok, pop;

  assign lane_valid = {bus.b_valid, bus.a_valid};
  assign lane_data  = {bus.b_data,  bus.a_data};

  assign load_ok = !out_valid_q || bus.out_ready;
  assign pop     = (&lane_nonempty) && load_ok && !bus.clear;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_deskew_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .PTR_W      (PTR_W)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .clear    (bus.clear),
      .in_valid (lane_valid[i]),
      .in_data  (lane_data[i]),
      .pop      (pop),
      .head     (lane_head[i]),
      .level    (lane_level[i]),
      .nonempty (lane_nonempty[i]),
      .full     (lane_full[i]),
      .drop     (lane_drop[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      overflow_q  <= 1'b0;
    end else if (bus.clear) begin
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (pop) begin
        out_valid_q <= 1'b1;
        out_a_q     <= lane_head[0];
        out_b_q     <= lane_head[1];
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (|lane_drop) overflow_q <= 1'b1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.overflow  = overflow_q;
  assign bus.a_level   = lane_level[0];
  assign bus.b_level   = lane_level[1];
  assign bus.a_full    = lane_full[0];
  assign bus.b_full    = lane_full[1];
endmodule

// File: tb/tb_lane_deskew_buffer.sv
// Directed bench for lane_deskew_buffer: reset, skew, backpressure/overflow,
// clear, full-with-pop and a long wrapping stream.
module tb_lane_deskew_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  lane_deskew_buffer_if #(.DATA_WIDTH(24), .PTR_W(4)) bus ();

  lane_deskew_buffer #(.DATA_WIDTH(24), .DEPTH(16), .PTR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [23:0] ad, input logic bv, input logic [23:0] bd);
    bus.a_valid = av;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_data  = bd;
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {3'b0, bus.out_valid, 3'b0, bus.overflow, 3'b0, bus.a_level, 3'b0, bus.b_level,
              6'b0, bus.a_full, bus.b_full}, 32'h0);
    chk({tag, "_data"}, {8'h0, bus.out_a | bus.out_b}, 32'h0);
  endtask

  initial begin
    int rcv, a_sent, b_sent, cyc;
    bus.clear = 0; bus.out_ready = 0;
    drive(0, 0, 0, 0);

    // 1. reset and idle
    #12 rst = 0;
    tick();
    all_zero("post_reset");
    bus.out_ready = 1;
    drive(1, 24'h77, 1, 24'h77);
    tick();
    drive(0, 0, 0, 0);
    tick();
    chk("pre_rst_valid", bus.out_valid, 1);
    chk("pre_rst_a", bus.out_a, 24'h77);
    #3 rst = 1;
    #1 all_zero("async_rst");
    #2 rst = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      all_zero("idle");
    end

    // 2. skewed alignment
    tick();
    for (int c = 0; c < 12; c++) begin
      chk("skew_valid", bus.out_valid, (c >= 7 && c <= 9) ? 1 : 0);
      if (c >= 7 && c <= 9) begin
        chk("skew_a", bus.out_a, c - 6);
        chk("skew_b", bus.out_b, c - 6);
      end
      if (c >= 3 && c <= 6) chk("skew_alevel", bus.a_level, 3);
      drive(c <= 2, 24'(c + 1), (c >= 5 && c <= 7), 24'(c - 4));
      tick();
    end
    drive(0, 0, 0, 0);
    chk("skew_drain_lvl", {bus.a_level, bus.b_level}, 0);
    chk("skew_ovf", bus.overflow, 0);

    // 3. backpressure and overflow
    bus.out_ready = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 24'(i + 1), 1, 24'(i + 1));
      tick();
    end
    drive(0, 0, 0, 0);
    chk("bp_hold_a", bus.out_a, 1);
    chk("bp_hold_b", bus.out_b, 1);
    chk("bp_valid", bus.out_valid, 1);
    chk("bp_alevel", bus.a_level, 16);
    chk("bp_blevel", bus.b_level, 16);
    chk("bp_full", {bus.a_full, bus.b_full}, 2'b11);
    chk("bp_ovf", bus.overflow, 1);
    bus.out_ready = 1;
    for (int k = 1; k <= 17; k++) begin
      chk("bp_drain_v", bus.out_valid, 1);
      chk("bp_drain_a", bus.out_a, k);
      chk("bp_drain_b", bus.out_b, k);
      tick();
    end
    chk("bp_end_valid", bus.out_valid, 0);
    chk("bp_ovf_sticky", bus.overflow, 1);

    // 5. clear mid-stream (overflow still set from above)
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 24'(i + 1), 1, 24'(i + 1));
      tick();
    end
    for (int i = 3; i < 6; i++) begin
      drive(1, 24'(i + 1), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0);
    chk("clr_pre_alevel", bus.a_level, 5);
    chk("clr_pre_blevel", bus.b_level, 2);
    chk("clr_pre_valid", bus.out_valid, 1);
    bus.clear = 1;
    drive(1, 24'hEE, 1, 24'hEE);
    tick();
    bus.clear = 0;
    drive(0, 0, 0, 0);
    all_zero_lv("clr_after");
    tick();
    tick();
    chk("clr_empty_lvl", {bus.a_level, bus.b_level}, 0);
    chk("clr_empty_v", bus.out_valid, 0);
    bus.out_ready = 1;
    drive(1, 24'h55, 1, 24'h55);
    tick();
    drive(0, 0, 0, 0);
    tick();
    chk("clr_next_a", bus.out_a, 24'h55);
    chk("clr_next_b", bus.out_b, 24'h55);
    tick();
    chk("clr_next_done", bus.out_valid, 0);

    // 4. full with simultaneous pop
    bus.out_ready = 0;
    for (int i = 0; i < 17; i++) begin
      drive(1, 24'(i + 1), 1, 24'(i + 1));
      tick();
    end
    chk("fp_alevel", bus.a_level, 16);
    chk("fp_full", {bus.a_full, bus.b_full}, 2'b11);
    chk("fp_ovf0", bus.overflow, 0);
    bus.out_ready = 1;
    drive(1, 24'hAA, 1, 24'hAA);
    tick();
    drive(0, 0, 0, 0);
    chk("fp_level_held", {bus.a_level, bus.b_level}, {5'd16, 5'd16});
    chk("fp_ovf_still0", bus.overflow, 0);
    for (int k = 2; k <= 17; k++) begin
      chk("fp_drain_a", bus.out_a, k);
      tick();
    end
    chk("fp_pair18_v", bus.out_valid, 1);
    chk("fp_pair18_a", bus.out_a, 24'hAA);
    chk("fp_pair18_b", bus.out_b, 24'hAA);
    tick();

    // 6. pointer wrap with lagging B and toggling ready
    rcv = 0; a_sent = 0; b_sent = 0; cyc = 0;
    while (rcv < 100 && cyc < 2000) begin
      bus.a_valid = (cyc % 2 == 0) && (a_sent < 100);
      bus.a_data  = 24'(1000 + a_sent);
      bus.b_valid = (cyc >= 3) && (cyc % 2 == 1) && (b_sent < 100);
      bus.b_data  = 24'(1000 + b_sent);
      bus.out_ready = (cyc % 2 == 0);
      if (bus.out_valid && bus.out_ready) begin
        chk("wrap_a", bus.out_a, 1000 + rcv);
        chk("wrap_b", bus.out_b, 1000 + rcv);
        rcv++;
      end
      chk("wrap_alevel_le16", bus.a_level <= 16, 1);
      if (bus.a_valid) a_sent++;
      if (bus.b_valid) b_sent++;
      tick();
      cyc++;
    end
    drive(0, 0, 0, 0);
    chk("wrap_count", rcv, 100);
    chk("wrap_ovf", bus.overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic all_zero_lv(input string tag);
    chk({tag, "_lvl"}, {bus.a_level, bus.b_level}, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_ovf"}, bus.overflow, 0);
  endtask
endmodule

// File: doc/lane_deskew_buffer.md
Name: lane_deskew_buffer

Overview:
- Receive-side counterpart to the fixed-latency delay chains. Two data lanes whose upstream paths have unequal, unknown or variable latency feed in. The block re-pairs them in arrival order and emits aligned (a, b) pairs through a valid/ready output.
- Sits at the join point of two datapath branches, e.g. butterfly operand and twiddle paths, replacing hand-tuned shift-chain padding.

Parameters:
- DATA_WIDTH, 24, width of each lane word
- DEPTH, 16, per-lane FIFO entries; power of two, at least 2
- PTR_W, 4, log2(DEPTH)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous flush of all state
- a_valid  in  1  lane A word present this cycle
- a_data  in  DATA_WIDTH  lane A word
- b_valid  in  1  lane B word present this cycle
- b_data  in  DATA_WIDTH  lane B word
- out_ready  in  1  consumer accepts the pair this cycle
- out_valid  out  1  aligned pair present
- out_a  out  DATA_WIDTH  lane A word of pair
- out_b  out  DATA_WIDTH  lane B word of pair
- a_level  out  PTR_W+1  lane A FIFO occupancy, 0..DEPTH
- b_level  out  PTR_W+1  lane B FIFO occupancy, 0..DEPTH
- a_full  out  1  a_level == DEPTH
- b_full  out  1  b_level == DEPTH
- overflow  out  1  sticky; a word was dropped on either lane

Behaviour:
- Reset (rst = 1, any time, asynchronous):
  - Pointers, levels, out_valid, out_a, out_b and overflow all go to 0.
  - FIFO storage contents are don't-care.
- Storage: two independent circular FIFOs, each with wr_ptr/rd_ptr of width PTR_W. Pointers wrap from DEPTH-1 to 0 with no bubble.
- Output stage: a single register pair (out_a, out_b) with out_valid.
  - out_a, out_b and out_valid are registers, not combinational from the FIFOs.
  - Stage may load when: load_ok = !out_valid || out_ready.
- Pop: pop = (a_level > 0) && (b_level > 0) && load_ok.
  - On pop, both lanes' head words load into out_a/out_b together, both rd_ptrs advance, and out_valid <= 1.
  - If !pop and out_ready, out_valid <= 0.
- Push, per lane X:
  - Accepted when X_valid && (X_level < DEPTH || pop).
  - An accepted push writes the FIFO at wr_ptr and advances wr_ptr.
  - A push at full with a simultaneous pop is accepted; level stays DEPTH.
- Drop: X_valid while full and no pop discards the word and sets overflow <= 1.
  - overflow stays set until clear or rst.
- Level update per lane: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency:
  - A word presented in cycle N is written at the edge ending N.
  - The pair leaves the FIFOs at the edge ending N+1, so out_valid is high in cycle N+2. This holds if the partner word is already present and the output stage is free.
  - Minimum latency is 2 cycles; steady-state throughput is 1 pair per cycle.
- Ordering: strict FIFO per lane. The k-th accepted A word is always paired with the k-th accepted B word.
- Backpressure: while out_valid && !out_ready, out_a, out_b and out_valid hold stable.
- clear (synchronous):
  - Has priority over push and pop in the same cycle; inputs in that cycle are ignored.
  - At the next edge, levels, pointers, out_valid and overflow all go to 0.
- Arithmetic: no data transformation; words pass through bit-exact. Levels never exceed DEPTH or go below 0.

Test Plan:
1. Reset and idle:
   - Assert rst mid-cycle with clk running -> all outputs 0 immediately.
   - Release with no inputs -> outputs stay 0 for 20 cycles.
2. Skewed alignment:
   - Stimulus: A pushes 0x000001..0x000003 in cycles 0-2; B pushes the same values in cycles 5-7; out_ready = 1.
   - Response: a_level reaches 3 and holds until B arrives; pairs (1,1), (2,2), (3,3) appear with out_valid in cycles 7, 8, 9.
   - After drain, levels are 0 and overflow is 0.
3. Backpressure and overflow:
   - Stimulus: out_ready = 0; both lanes push 0x000001..0x000014 (20 words) on consecutive cycles.
   - Response: out holds (1,1); both levels reach 16 with a_full = b_full = 1; words 18-20 are dropped and overflow = 1.
   - Then set out_ready = 1: exactly pairs 1..17 are delivered in order, and overflow remains 1.
4. Full with simultaneous pop:
   - Stimulus: fill as in scenario 3 without overflowing (17 words); then raise out_ready and, in the same cycle, push 0x0000AA on both lanes.
   - Response: push is accepted, level stays 16, overflow stays 0, and 0x0000AA emerges as pair 18.
5. Clear mid-stream:
   - Stimulus: with 5 words queued on A, 2 on B and out_valid = 1, assert clear together with a_valid and b_valid.
   - Response: next cycle levels = 0, out_valid = 0, overflow = 0, and the words pushed during clear are absent.
6. Pointer wrap:
   - Stimulus: stream 100 pairs, with B lagging A by 3 cycles and out_ready toggling 1/0 every cycle.
   - Response: every output pair has out_a == out_b, in incrementing sequence; no drops; a_level never exceeds 16.
